// File: rtl/sw_host_driver_if.sv
// Core-side bus of the Smith-Waterman host driver: T stream, start, S chunk
// handshake and result return. master = host driver, slave = accelerator core.
interface sw_host_driver_if #(
  parameter int unsigned PE_SIZE = 8,
  parameter int unsigned PE_LOG  = 3,
  parameter int unsigned VEF_W   = 16
);
  logic                   set_t;
  logic [17:0]            t;
  logic                   start_cal;
  logic                   core_busy;
  logic                   request_s;
  logic [2*PE_SIZE-1:0]   s;
  logic [PE_LOG:0]        s_valid;
  logic [VEF_W-1:0]       result;
  logic                   result_valid;

  modport master (
    output set_t, t, start_cal, s, s_valid,
    input  core_busy, request_s, result, result_valid
  );

  modport slave (
    input  set_t, t, start_cal, s, s_valid,
    output core_busy, request_s, result, result_valid
  );
endinterface

// File: rtl/sw_host_driver.sv
// Host-side driver for the Smith-Waterman core: buffers T and S, streams T,
// starts the core, serves S chunks on request and captures the final score.
module sw_host_driver #(
  parameter int unsigned PE_SIZE   = 8,
  parameter int unsigned PE_LOG    = 3,
  parameter int unsigned T_MAX_LOG = 10,
  parameter int unsigned S_MAX_LOG = 12,
  parameter int unsigned VEF_W     = 16,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_ld_we,
  input  logic                   i_ld_sel,
  input  logic [S_MAX_LOG-1:0]   i_ld_addr,
  input  logic [1:0]             i_ld_base,
  input  logic [T_MAX_LOG:0]     i_t_len,
  input  logic [S_MAX_LOG:0]     i_s_len,
  input  logic                   i_go,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [VEF_W-1:0]       o_score,
  output logic                   o_set_t,
  output logic [17:0]            o_t,
  output logic                   o_start_cal,
  input  logic                   i_core_busy,
  input  logic                   i_request_s,
  output logic [2*PE_SIZE-1:0]   o_s,
  output logic [PE_LOG:0]        o_s_valid,
  input  logic [VEF_W-1:0]       i_result,
  input  logic                   i_result_valid
);

  localparam int unsigned CW    = 2 * PE_SIZE;
  localparam int unsigned TW_N  = 1 << (T_MAX_LOG - PE_LOG);
  localparam int unsigned SW_N  = 1 << (S_MAX_LOG - PE_LOG);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [PE_LOG:0]  PE_N     = PE_SIZE[PE_LOG:0];

  typedef enum logic [2:0] {IDLE, SETT, SEND_T, WAIT_T, START, SERVE} state_t;

  state_t state_q, state_d;

  // Buffers hold one chunk per word so a whole chunk is read in one cycle.
  logic [CW-1:0] t_mem_q [TW_N];
  logic [CW-1:0] s_mem_q [SW_N];

  logic [T_MAX_LOG:0]            t_rem_q, t_rem_d;
  logic [S_MAX_LOG:0]            s_rem_q, s_rem_d;
  logic [T_MAX_LOG-PE_LOG-1:0]   t_wi_q, t_wi_d;
  logic [S_MAX_LOG-PE_LOG-1:0]   s_wi_q, s_wi_d;
  logic [TMO_W-1:0]              tmo_q, tmo_d;
  logic                          seen_q, seen_d;

  logic                          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [VEF_W-1:0]              score_q, score_d;
  logic                          set_t_q, set_t_d, start_q, start_d;
  logic [17:0]                   t_q, t_d;
  logic [CW-1:0]                 s_q, s_d;
  logic [PE_LOG:0]               s_valid_q, s_valid_d;

  logic [PE_LOG:0]               t_n, s_n;
  logic                          t_last, ld_ok;

  function automatic logic [PE_LOG:0] take(input logic [S_MAX_LOG:0] rem);
    if (rem >= {{(S_MAX_LOG-PE_LOG){1'b0}}, PE_N}) return PE_N;
    else return rem[PE_LOG:0];
  endfunction

  function automatic logic [CW-1:0] mask(input logic [CW-1:0] w, input logic [PE_LOG:0] n);
    logic [CW-1:0] m;
    m = w;
    for (int unsigned k = 0; k < PE_SIZE; k++)
      if (k >= 32'(n)) m[2*k +: 2] = 2'b00;
    return m;
  endfunction

  assign ld_ok  = i_ld_we && (state_q == IDLE);
  assign t_n    = take({{(S_MAX_LOG-T_MAX_LOG){1'b0}}, t_rem_q});
  assign s_n    = take(s_rem_q);
  assign t_last = (t_rem_q <= {{(T_MAX_LOG-PE_LOG){1'b0}}, PE_N});

  always_ff @(posedge clk) begin
    if (ld_ok && !i_ld_sel)
      t_mem_q[i_ld_addr[T_MAX_LOG-1:PE_LOG]][{i_ld_addr[PE_LOG-1:0], 1'b0} +: 2] <= i_ld_base;
    if (ld_ok && i_ld_sel)
      s_mem_q[i_ld_addr[S_MAX_LOG-1:PE_LOG]][{i_ld_addr[PE_LOG-1:0], 1'b0} +: 2] <= i_ld_base;
  end

  always_comb begin
    state_d   = state_q;
    t_rem_d   = t_rem_q;
    s_rem_d   = s_rem_q;
    t_wi_d    = t_wi_q;
    s_wi_d    = s_wi_q;
    tmo_d     = tmo_q;
    seen_d    = seen_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    score_d   = score_q;
    set_t_d   = 1'b0;
    t_d       = '0;
    start_d   = 1'b0;
    s_d       = '0;
    s_valid_d = '0;

    case (state_q)
      IDLE: begin
        if (i_go) begin
          if (i_t_len != '0 && i_s_len != '0) begin
            t_rem_d = i_t_len;
            s_rem_d = i_s_len;
            t_wi_d  = '0;
            s_wi_d  = '0;
            busy_d  = 1'b1;
            state_d = SETT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETT: begin
        set_t_d = 1'b1;
        state_d = SEND_T;
      end
      SEND_T: begin
        t_d     = {1'b1, t_last, mask(t_mem_q[t_wi_q], t_n)};
        t_rem_d = t_rem_q - {{(T_MAX_LOG-PE_LOG){1'b0}}, t_n};
        t_wi_d  = t_wi_q + 1'b1;
        if (t_last) begin
          tmo_d   = '0;
          seen_d  = 1'b0;
          state_d = WAIT_T;
        end
      end
      WAIT_T: begin
        tmo_d = tmo_q + 1'b1;
        if (i_core_busy) seen_d = 1'b1;
        // Busy must be observed high on an earlier cycle before its low level counts.
        if (seen_q && !i_core_busy) begin
          state_d = START;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      START: begin
        start_d = 1'b1;
        tmo_d   = '0;
        state_d = SERVE;
      end
      SERVE: begin
        if (i_result_valid) begin
          score_d = i_result;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (i_request_s) begin
          tmo_d = '0;
          if (s_rem_q != '0) begin
            s_d       = mask(s_mem_q[s_wi_q], s_n);
            s_valid_d = s_n;
            s_rem_d   = s_rem_q - {{(S_MAX_LOG-PE_LOG){1'b0}}, s_n};
            s_wi_d    = s_wi_q + 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      t_rem_q   <= '0;
      s_rem_q   <= '0;
      t_wi_q    <= '0;
      s_wi_q    <= '0;
      tmo_q     <= '0;
      seen_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      score_q   <= '0;
      set_t_q   <= 1'b0;
      t_q       <= '0;
      start_q   <= 1'b0;
      s_q       <= '0;
      s_valid_q <= '0;
    end else begin
      state_q   <= state_d;
      t_rem_q   <= t_rem_d;
      s_rem_q   <= s_rem_d;
      t_wi_q    <= t_wi_d;
      s_wi_q    <= s_wi_d;
      tmo_q     <= tmo_d;
      seen_q    <= seen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      score_q   <= score_d;
      set_t_q   <= set_t_d;
      t_q       <= t_d;
      start_q   <= start_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_score     = score_q;
  assign o_set_t     = set_t_q;
  assign o_t         = t_q;
  assign o_start_cal = start_q;
  assign o_s         = s_q;
  assign o_s_valid   = s_valid_q;

endmodule

// File: tb/tb_sw_host_driver.sv
// Self-checking bench for sw_host_driver: table of S-serving transactions plus
// hand-written sequences for result/request collision, errors, timeout and reset.
module tb_sw_host_driver;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ld_we, i_ld_sel, i_go;
  logic [11:0] i_ld_addr;
  logic [1:0]  i_ld_base;
  logic [10:0] i_t_len;
  logic [12:0] i_s_len;
  logic        o_busy, o_done, o_err;
  logic [15:0] o_score;

  always #5 clk = ~clk;

  sw_host_driver_if #(.PE_SIZE(8), .PE_LOG(3), .VEF_W(16)) cif ();

  sw_host_driver #(
    .PE_SIZE(8), .PE_LOG(3), .T_MAX_LOG(10), .S_MAX_LOG(12), .VEF_W(16), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ld_we(i_ld_we), .i_ld_sel(i_ld_sel), .i_ld_addr(i_ld_addr), .i_ld_base(i_ld_base),
    .i_t_len(i_t_len), .i_s_len(i_s_len), .i_go(i_go),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_score(o_score),
    .o_set_t(cif.set_t), .o_t(cif.t), .o_start_cal(cif.start_cal),
    .i_core_busy(cif.core_busy), .i_request_s(cif.request_s),
    .o_s(cif.s), .o_s_valid(cif.s_valid),
    .i_result(cif.result), .i_result_valid(cif.result_valid)
  );

  typedef struct packed {
    int              s_len;
    int              nreq;
    logic [4:0][3:0] exp_v;
    logic [15:0]     res;
  } vec_t;

  typedef struct packed {
    logic [3:0]  v;
    logic [15:0] s;
  } chunk_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [1:0]  t_bases [16];
  logic [1:0]  s_bases [24];
  int          pos;
  int          kk;
  logic [17:0] last_tw;
  logic [17:0] tq [$];
  chunk_t      sb [$];
  vec_t        vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_assert++;
    n_fail++;
    $display("FAIL %s: wait bound expired, actual=none required=event", nm);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".busy"},    32'(o_busy), 0);
    chk({nm, ".done"},    32'(o_done), 0);
    chk({nm, ".err"},     32'(o_err), 0);
    chk({nm, ".score"},   32'(o_score), 0);
    chk({nm, ".set_t"},   32'(cif.set_t), 0);
    chk({nm, ".t"},       32'(cif.t), 0);
    chk({nm, ".start"},   32'(cif.start_cal), 0);
    chk({nm, ".s"},       32'(cif.s), 0);
    chk({nm, ".s_valid"}, 32'(cif.s_valid), 0);
  endtask

  task automatic ld(input logic sel, input int addr, input logic [1:0] base);
    i_ld_we = 1'b1; i_ld_sel = sel; i_ld_addr = 12'(addr); i_ld_base = base;
    tick();
    i_ld_we = 1'b0;
  endtask

  function automatic logic [17:0] exp_tword(input int w, input int tlen);
    logic [15:0] d = '0;
    int n = tlen - 8*w;
    if (n > 8) n = 8;
    for (int k = 0; k < n; k++) d[2*k +: 2] = t_bases[8*w + k];
    return {1'b1, (tlen - 8*w <= 8), d};
  endfunction

  function automatic logic [15:0] mk_chunk(input int n);
    logic [15:0] d = '0;
    for (int k = 0; k < n; k++) d[2*k +: 2] = s_bases[pos + k];
    return d;
  endfunction

  // Starts a transaction and follows it up to o_start_cal (or o_err when the core is dead).
  task automatic front(input int tlen, input int slen, input bit dead, output int kout);
    int  j;
    bit  t_done;
    logic [17:0] e;
    tq.delete();
    for (int w = 0; w < (tlen + 7) / 8; w++) tq.push_back(exp_tword(w, tlen));
    i_t_len = 11'(tlen); i_s_len = 13'(slen); i_go = 1'b1;
    tick();
    i_go = 1'b0;
    chk("busy_after_go", 32'(o_busy), 1);
    j = 0;
    while (!cif.set_t && j < 4) begin tick(); j++; end
    chk("set_t_seen", 32'(cif.set_t), 1);
    kout = -1;
    t_done = 1'b0;
    for (int k = 1; k <= TO + 20 && kout < 0; k++) begin
      tick();
      if (k == 1) chk("set_t_one_cycle", 32'(cif.set_t), 0);
      if (tq.size() > 0) begin
        e = tq.pop_front();
        last_tw = cif.t;
        chk("t_word", 32'(cif.t), 32'(e));
      end else if (!t_done) begin
        t_done = 1'b1;
        chk("t_idle", 32'(cif.t), 0);
      end
      if (!dead && k == 3) cif.core_busy = 1'b1;
      if (!dead && k == 7) cif.core_busy = 1'b0;
      if (!dead && cif.start_cal) kout = k;
      if (dead && o_err) kout = k;
    end
    if (kout < 0) bound_fail(dead ? "timeout_err" : "start_cal");
  endtask

  task automatic serve(input int nreq, input logic [4:0][3:0] ev);
    chunk_t c, got;
    pos = 0;
    for (int k = 0; k < nreq; k++) begin
      c.v = ev[k];
      c.s = mk_chunk(int'(ev[k]));
      pos += int'(ev[k]);
      sb.push_back(c);
      cif.request_s = 1'b1;
      tick();
      got = sb.pop_front();
      chk("s_valid", 32'(cif.s_valid), 32'(got.v));
      chk("s_data",  32'(cif.s),       32'(got.s));
    end
    cif.request_s = 1'b0;
    tick();
    chk("s_no_req", 32'(cif.s_valid), 0);
  endtask

  task automatic finish_txn(input logic [15:0] res);
    cif.result = res; cif.result_valid = 1'b1;
    tick();
    cif.result_valid = 1'b0;
    chk("done",       32'(o_done), 1);
    chk("score",      32'(o_score), 32'(res));
    chk("busy_drop",  32'(o_busy), 0);
    tick();
    chk("done_pulse", 32'(o_done), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    front(10, v.s_len, 1'b0, k);
    chk("start_cal_lat", 32'(k), 9);
    tick();
    chk("start_one_cycle", 32'(cif.start_cal), 0);
    serve(v.nreq, v.exp_v);
    finish_txn(v.res);
  endtask

  initial begin
    rst = 1'b1; i_ld_we = 1'b0; i_ld_sel = 1'b0; i_ld_addr = '0; i_ld_base = '0;
    i_t_len = '0; i_s_len = '0; i_go = 1'b0;
    cif.core_busy = 1'b0; cif.request_s = 1'b0; cif.result = '0; cif.result_valid = 1'b0;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      t_bases[i] = 2'(i % 4);
      ld(1'b0, i, t_bases[i]);
    end
    for (int i = 0; i < 20; i++) begin
      s_bases[i] = 2'($urandom_range(0, 3));
      ld(1'b1, i, s_bases[i]);
    end

    vecs[0] = '{s_len: 20, nreq: 4, exp_v: 20'h00488, res: 16'd123};
    vecs[1] = '{s_len: 16, nreq: 3, exp_v: 20'h00088, res: 16'd7};
    vecs[2] = '{s_len: 5,  nreq: 2, exp_v: 20'h00005, res: 16'hBEEF};
    vecs[3] = '{s_len: 8,  nreq: 2, exp_v: 20'h00008, res: 16'd0};
    vecs[4] = '{s_len: 1,  nreq: 1, exp_v: 20'h00001, res: 16'd255};
    vecs[5] = '{s_len: 9,  nreq: 3, exp_v: 20'h00018, res: 16'd9};
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    chk("t_last_word_acgt", 32'(last_tw), 32'h30004);

    // Result collides with a request; a write and i_go during SERVE are ignored.
    front(10, 20, 1'b0, kk);
    chk("start_cal_lat", 32'(kk), 9);
    tick();
    serve(1, 20'h00008);
    i_ld_we = 1'b1; i_ld_sel = 1'b1; i_ld_addr = '0; i_ld_base = ~s_bases[0];
    i_go = 1'b1; i_t_len = 11'd10; i_s_len = 13'd20;
    tick();
    i_ld_we = 1'b0; i_go = 1'b0;
    chk("go_ignored_set_t", 32'(cif.set_t), 0);
    chk("go_ignored_busy",  32'(o_busy), 1);
    cif.request_s = 1'b1; cif.result = 16'd37; cif.result_valid = 1'b1;
    tick();
    cif.request_s = 1'b0; cif.result_valid = 1'b0;
    chk("collide_s_valid", 32'(cif.s_valid), 0);
    chk("collide_s",       32'(cif.s), 0);
    chk("collide_done",    32'(o_done), 1);
    chk("collide_score",   32'(o_score), 37);
    chk("collide_busy",    32'(o_busy), 0);
    tick();
    chk("collide_done_once", 32'(o_done), 0);

    // Zero lengths.
    i_t_len = '0; i_s_len = 13'd20; i_go = 1'b1;
    tick();
    i_go = 1'b0;
    chk("tlen0_err",  32'(o_err), 1);
    chk("tlen0_busy", 32'(o_busy), 0);
    tick();
    chk("tlen0_err_pulse", 32'(o_err), 0);
    chk("tlen0_no_set_t",  32'(cif.set_t), 0);
    tick();
    chk("tlen0_no_set_t2", 32'(cif.set_t), 0);
    i_t_len = 11'd10; i_s_len = '0; i_go = 1'b1;
    tick();
    i_go = 1'b0;
    chk("slen0_err",  32'(o_err), 1);
    chk("slen0_busy", 32'(o_busy), 0);

    // Core never raises busy.
    tick();
    front(10, 20, 1'b1, kk);
    chk("timeout_lat",   32'(kk), TO + 2);
    chk("timeout_busy",  32'(o_busy), 0);
    chk("timeout_score", 32'(o_score), 37);
    tick();
    chk("timeout_err_pulse", 32'(o_err), 0);

    // Reset during SERVE, then a full transaction.
    front(10, 20, 1'b0, kk);
    chk("start_cal_lat", 32'(kk), 9);
    tick();
    serve(1, 20'h00008);
    cif.request_s = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; cif.request_s = 1'b0;
    chk_zero("rst_serve");
    tick();
    chk("rst_no_done", 32'(o_done), 0);
    chk("rst_no_err",  32'(o_err), 0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
